// File: rtl/jk_machine_sequencer.sv
// Bring-up sequencer for one serial Moore FSM: resets it, streams pattern bits MSB first
// (pattern[PAT_W-1] downward), counts F-high samples. Optional JK_SEQ_STATE_CHECK_EN adds a post-reset S check.
module jk_machine_sequencer #(
   parameter int unsigned PAT_W   = 16,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned RST_CYC = 2
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       start,
   input  logic [PAT_W-1:0]           pattern,
   input  logic [$clog2(PAT_W+1)-1:0] len,
   output logic                       busy,
   output logic                       done,
   output logic [CNT_W-1:0]           hit_count,
   output logic                       err,
   output logic                       mach_reset,
   output logic                       x_out,
   input  logic                       f_in,
   input  logic [2:0]                 s_in
);

   localparam int unsigned LEN_W = $clog2(PAT_W + 1);
   localparam int unsigned RC_W  = (RST_CYC < 2) ? 1 : $clog2(RST_CYC);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
   localparam logic [CNT_W-1:0] HIT_MAX = '1;
   localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYC - 1);

   typedef enum logic [2:0] {S_IDLE, S_MRST, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_nx;
   logic [PAT_W-1:0]  pat_q;
   logic [LEN_W-1:0]  rem_q;
   logic [RC_W-1:0]   rcnt_q;
   logic              first_q;
   logic              capture, load_bit, sample;
   logic              busy_nx, done_nx, mrst_nx, x_nx;

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) state_q <= S_IDLE;
      else       state_q <= state_nx;
   end

   // Next-state logic; rem_q counts bits not yet placed on x_out
   always_comb begin
      state_nx = state_q;
      case (state_q)
         S_IDLE:  if (start) state_nx = (len == '0) ? S_DONE : S_MRST;
         S_MRST:  if (rcnt_q == RC_LAST) state_nx = S_RUN;
         S_RUN:   if (rem_q == '0) state_nx = S_DRAIN;
         S_DRAIN: state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Output/datapath controls, computed from the next state so outputs can be registered
   always_comb begin
      capture  = (state_q == S_IDLE) && start;
      load_bit = (state_nx == S_RUN);
      sample   = ((state_q == S_RUN) && !first_q) || (state_q == S_DRAIN);
      busy_nx  = (state_nx != S_IDLE);
      done_nx  = (state_nx == S_DONE);
      mrst_nx  = !((state_nx == S_RUN) || (state_nx == S_DRAIN));
      x_nx     = load_bit ? pat_q[PAT_W-1] : 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         mach_reset <= 1'b1;
         x_out      <= 1'b0;
         hit_count  <= '0;
         pat_q      <= '0;
         rem_q      <= '0;
         rcnt_q     <= '0;
         first_q    <= 1'b0;
      end else begin
         busy       <= busy_nx;
         done       <= done_nx;
         mach_reset <= mrst_nx;
         x_out      <= x_nx;
         first_q    <= (state_q == S_MRST) && (state_nx == S_RUN);
         rcnt_q     <= (state_q == S_MRST) ? rcnt_q + RC_W'(1) : '0;
         if (capture) begin
            pat_q     <= pattern;
            rem_q     <= (len > LEN_MAX) ? LEN_MAX : len;
            hit_count <= '0;
         end else begin
            if (load_bit) begin
               pat_q <= pat_q << 1;
               rem_q <= rem_q - LEN_W'(1);
            end
            if (sample && f_in && (hit_count != HIT_MAX))
               hit_count <= hit_count + CNT_W'(1);
         end
      end
   end

`ifdef JK_SEQ_STATE_CHECK_EN
   // FSM must report S==0 on the first cycle out of reset
   always_ff @(posedge CLK) begin
      if (RESET)                                             err <= 1'b0;
      else if (capture)                                      err <= 1'b0;
      else if ((state_q == S_RUN) && first_q && (s_in != 3'b000)) err <= 1'b1;
   end
`else
   logic unused_s;
   assign unused_s = ^s_in;
   assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_jk_machine_sequencer.sv
// Self-checking bench for jk_machine_sequencer: two instances (CNT_W=8 and CNT_W=2) driven
// identically, each with an F=x-registered stub FSM, checked against a pattern-level model.
module tb_jk_machine_sequencer;

   localparam int RST_T = 2;

   logic        CLK = 1'b0;
   logic        RESET, start, bad_s;
   logic [15:0] pattern;
   logic [4:0]  len;

   logic        busy_a, done_a, err_a, mr_a, x_a, f_a, mrd_a;
   logic [7:0]  hit_a;
   logic [2:0]  s_a;
   logic        busy_b, done_b, err_b, mr_b, x_b, f_b, mrd_b;
   logic [1:0]  hit_b;
   logic [2:0]  s_b;

   int npass = 0;
   int nchk  = 0;

   always #5 CLK = ~CLK;

   jk_machine_sequencer #(.PAT_W(16), .CNT_W(8), .RST_CYC(RST_T)) dut_a (
      .CLK(CLK), .RESET(RESET), .start(start), .pattern(pattern), .len(len),
      .busy(busy_a), .done(done_a), .hit_count(hit_a), .err(err_a),
      .mach_reset(mr_a), .x_out(x_a), .f_in(f_a), .s_in(s_a));

   jk_machine_sequencer #(.PAT_W(16), .CNT_W(2), .RST_CYC(RST_T)) dut_b (
      .CLK(CLK), .RESET(RESET), .start(start), .pattern(pattern), .len(len),
      .busy(busy_b), .done(done_b), .hit_count(hit_b), .err(err_b),
      .mach_reset(mr_b), .x_out(x_b), .f_in(f_b), .s_in(s_b));

   // Stub FSMs: F = x registered, cleared by their RESET; optional bad S on first cycle out of reset
   always_ff @(posedge CLK) begin
      f_a   <= mr_a ? 1'b0 : x_a;
      f_b   <= mr_b ? 1'b0 : x_b;
      mrd_a <= mr_a;
      mrd_b <= mr_b;
   end
   assign s_a = (bad_s && mrd_a && !mr_a) ? 3'b101 : {2'b00, f_a};
   assign s_b = (bad_s && mrd_b && !mr_b) ? 3'b101 : {2'b00, f_b};

   task automatic do_run(input logic [15:0] p, input logic [4:0] l, input bit bad,
                         output int dcyc, output int bcnt, output logic [7:0] ha,
                         output logic [1:0] hb, output logic ea, output logic e1,
                         output logic [31:0] xs, output int xn, output logic da,
                         output logic ba, output logic ma);
      ha = '0; hb = '0; ea = 1'b0; da = 1'bx; ba = 1'bx; ma = 1'bx;
      @(negedge CLK);
      start = 1'b1; pattern = p; len = l; bad_s = bad;
      @(negedge CLK);
      start = 1'b0; pattern = 16'($urandom); len = 5'($urandom);
      dcyc = -1; bcnt = 0; xn = 0; xs = '0; e1 = err_a;
      for (int c = 1; c <= 100; c++) begin
         if (busy_a) bcnt++;
         if (!mr_a) begin
            if (xn < 32) xs[xn] = x_a;
            xn++;
         end
         if (done_a) begin
            dcyc = c; ha = hit_a; hb = hit_b; ea = err_a;
            @(negedge CLK);
            da = done_a; ba = busy_a; ma = mr_a;
            break;
         end
         @(negedge CLK);
      end
      bad_s = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1; start = 1'b0; pattern = '0; len = '0; bad_s = 1'b0;
      repeat (2) @(negedge CLK);
      nchk++; if (busy_a !== 1'b0) $display("FAIL reset busy got=%b want=0", busy_a); else npass++;
      nchk++; if (done_a !== 1'b0) $display("FAIL reset done got=%b want=0", done_a); else npass++;
      nchk++; if (hit_a !== 8'd0)  $display("FAIL reset hit got=%0d want=0", hit_a); else npass++;
      nchk++; if (err_a !== 1'b0)  $display("FAIL reset err got=%b want=0", err_a); else npass++;
      nchk++; if (mr_a !== 1'b1)   $display("FAIL reset mach_reset got=%b want=1", mr_a); else npass++;
      nchk++; if (x_a !== 1'b0)    $display("FAIL reset x_out got=%b want=0", x_a); else npass++;
      nchk++; if (hit_b !== 2'd0)  $display("FAIL reset hit_b got=%0d want=0", hit_b); else npass++;
      RESET = 1'b0;
   endtask

   // One full run compared with the pattern-level model
   task automatic test_stream(input string name, input logic [15:0] p, input logic [4:0] l,
                              input bit bad);
      int dcyc, bcnt, xn, lc, h, edc;
      logic [7:0]  ha;
      logic [1:0]  hb;
      logic        ea, e1, da, ba, ma, eerr;
      logic [31:0] xs, exs;
      lc  = (int'(l) > 16) ? 16 : int'(l);
      h   = 0;
      exs = '0;
      for (int k = 0; k < lc; k++) begin
         exs[k] = p[15-k];
         h += int'(p[15-k]);
      end
      edc = (lc == 0) ? 1 : RST_T + lc + 2;
`ifdef JK_SEQ_STATE_CHECK_EN
      eerr = bad && (lc > 0);
`else
      eerr = 1'b0;
`endif
      do_run(p, l, bad, dcyc, bcnt, ha, hb, ea, e1, xs, xn, da, ba, ma);
      nchk++; if (dcyc !== edc) $display("FAIL %s done_cycle got=%0d want=%0d", name, dcyc, edc); else npass++;
      nchk++; if (bcnt !== edc) $display("FAIL %s busy_cycles got=%0d want=%0d", name, bcnt, edc); else npass++;
      nchk++; if (xn !== ((lc == 0) ? 0 : lc + 1))
         $display("FAIL %s run_cycles got=%0d want=%0d", name, xn, (lc == 0) ? 0 : lc + 1); else npass++;
      nchk++; if (xs !== exs) $display("FAIL %s x_stream got=%h want=%h", name, xs, exs); else npass++;
      nchk++; if (ha !== 8'((h > 255) ? 255 : h)) $display("FAIL %s hit8 got=%0d want=%0d", name, ha, h); else npass++;
      nchk++; if (hb !== 2'((h > 3) ? 3 : h))
         $display("FAIL %s hit2 got=%0d want=%0d", name, hb, (h > 3) ? 3 : h); else npass++;
      nchk++; if (ea !== eerr) $display("FAIL %s err got=%b want=%b", name, ea, eerr); else npass++;
      nchk++; if (e1 !== 1'b0) $display("FAIL %s err_clear got=%b want=0", name, e1); else npass++;
      nchk++; if (da !== 1'b0) $display("FAIL %s done_pulse got=%b want=0", name, da); else npass++;
      nchk++; if (ba !== 1'b0) $display("FAIL %s busy_after got=%b want=0", name, ba); else npass++;
      nchk++; if (ma !== 1'b1) $display("FAIL %s mreset_after got=%b want=1", name, ma); else npass++;
      repeat (2) @(negedge CLK);
      nchk++; if (hit_a !== 8'(h)) $display("FAIL %s hit_hold got=%0d want=%0d", name, hit_a, h); else npass++;
      nchk++; if (err_a !== eerr) $display("FAIL %s err_hold got=%b want=%b", name, err_a, eerr); else npass++;
   endtask

   task automatic test_start_ignored();
      int dcyc;
      logic [7:0] ha;
      @(negedge CLK);
      start = 1'b1; pattern = 16'hA5F0; len = 5'd16;
      @(negedge CLK);
      start = 1'b0; dcyc = -1; ha = '0;
      for (int c = 1; c <= 100; c++) begin
         if (done_a) begin
            dcyc = c; ha = hit_a; start = 1'b0;
            break;
         end
         start = (c == 4) || (c == 10);
         pattern = 16'($urandom); len = 5'd3;
         @(negedge CLK);
      end
      nchk++; if (dcyc !== RST_T + 18) $display("FAIL start_ignored done_cycle got=%0d want=%0d", dcyc, RST_T + 18); else npass++;
      nchk++; if (ha !== 8'd8) $display("FAIL start_ignored hit got=%0d want=8", ha); else npass++;
      repeat (2) @(negedge CLK);
   endtask

   task automatic test_mid_reset();
      int nd, nb;
      @(negedge CLK);
      start = 1'b1; pattern = 16'hFFFF; len = 5'd16;
      @(negedge CLK);
      start = 1'b0;
      repeat (RST_T + 5) @(negedge CLK);
      nchk++; if (mr_a !== 1'b0) $display("FAIL mid_reset in_run got=%b want=0", mr_a); else npass++;
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      nchk++; if (busy_a !== 1'b0) $display("FAIL mid_reset busy got=%b want=0", busy_a); else npass++;
      nchk++; if (mr_a !== 1'b1)   $display("FAIL mid_reset mach_reset got=%b want=1", mr_a); else npass++;
      nchk++; if (hit_a !== 8'd0)  $display("FAIL mid_reset hit got=%0d want=0", hit_a); else npass++;
      nchk++; if (x_a !== 1'b0)    $display("FAIL mid_reset x_out got=%b want=0", x_a); else npass++;
      nd = 0; nb = 0;
      for (int c = 0; c < 30; c++) begin
         if (done_a) nd++;
         if (busy_a) nb++;
         @(negedge CLK);
      end
      nchk++; if (nd !== 0) $display("FAIL mid_reset done_count got=%0d want=0", nd); else npass++;
      nchk++; if (nb !== 0) $display("FAIL mid_reset busy_count got=%0d want=0", nb); else npass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++)
         test_stream("random", 16'($urandom), 5'($urandom_range(0, 20)), bit'($urandom_range(0, 1)));
   endtask

   initial begin
      test_reset();
      test_stream("t1_a5f0", 16'hA5F0, 5'd16, 1'b0);
      test_stream("t2_len0", 16'hFFFF, 5'd0, 1'b0);
      test_stream("t3_saturate", 16'hFFFF, 5'd16, 1'b0);
      test_stream("t6_clamp", 16'h3C5A, 5'd20, 1'b0);
      test_stream("short", 16'hC000, 5'd1, 1'b0);
      test_start_ignored();
      test_mid_reset();
      test_stream("t5_bad_state", 16'h8001, 5'd16, 1'b1);
      test_stream("t5_clear", 16'h0F0F, 5'd9, 1'b0);
      test_random();
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
